axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width (only 64 supported).
REQ-003 SHALL have parameter MEM_WORDS, default 4096, backing array depth in 64-bit words.
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from AR handshake to first R beat (min 1).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have AR ports: s_axi_arvalid in 1, s_axi_arready out 1, s_axi_araddr in ADDR_WIDTH, s_axi_arlen in 8, s_axi_arsize in 3, s_axi_arburst in 2.
REQ-008 SHALL have R ports: s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rdata out 64, s_axi_rlast out 1, s_axi_rresp out 2.
REQ-009 SHALL have AW ports: s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awaddr in ADDR_WIDTH, s_axi_awlen in 8, s_axi_awsize in 3, s_axi_awburst in 2.
REQ-010 SHALL have W/B ports: s_axi_wvalid in 1, s_axi_wready out 1, s_axi_wdata in 64, s_axi_wstrb in 8, s_axi_wlast in 1, s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out 2.
REQ-011 SHALL have AC ports: s_axi_acvalid out 1, s_axi_acready in 1, s_axi_acaddr out ADDR_WIDTH, s_axi_acsnoop out 4.

Function
REQ-012 Read FSM SHALL use states R_IDLE, R_WAIT, R_BURST; s_axi_arready=1 only in R_IDLE.
REQ-013 On AR handshake SHALL latch addr/len/size/burst, go R_WAIT, count READ_LATENCY-1 cycles, then R_BURST with rvalid=1.
REQ-014 Beat count SHALL be arlen+1; rlast=1 on final beat only; after final rvalid&&rready SHALL return to R_IDLE the next cycle.
REQ-015 rvalid, rdata, rlast, rresp SHALL be held stable while rvalid&&!rready.
REQ-016 rdata SHALL be mem[addr[3+:log2(MEM_WORDS)]] for the current beat address; rresp=2'b00.
REQ-017 Beat address with (addr>>3)>=MEM_WORDS SHALL return rdata=0, rresp=2'b10 (SLVERR); burst continues.
REQ-018 Next-beat address: FIXED(00) unchanged; INCR(01) +(1<<size); WRAP(10) +(1<<size) wrapping at boundary (len+1)<<size; burst 11 treated as INCR.
REQ-019 Write FSM SHALL use states W_IDLE, W_DATA, W_SNOOP, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA.
REQ-020 Each W handshake SHALL write byte i of mem word when wstrb[i]=1; out-of-range beats SHALL be dropped and flag error.
REQ-021 W_DATA SHALL exit after awlen+1 beats; wlast not matching final beat SHALL set bresp=2'b10, else 2'b00.
REQ-022 W_RESP SHALL hold bvalid=1 until bready, then go W_IDLE.
REQ-023 Read and write FSMs SHALL run concurrently; a write beat committed at edge N SHALL be visible to a read beat presented at cycle N+1 or later.

Reset
REQ-024 On reset both FSMs SHALL go idle; all valid/ready outputs, rdata, rlast, rresp, bresp, acaddr, acsnoop SHALL be 0.
REQ-025 Reset mid-burst SHALL abandon the transaction without further beats or response; memory contents SHALL NOT be cleared.

Configuration
REQ-026 With AXI_MEM_SNOOP_EN defined, W_DATA SHALL go to W_SNOOP: acvalid=1, acaddr={awaddr[ADDR_WIDTH-1:6],6'b0}, acsnoop=4'hD, held until acready, then W_RESP.
REQ-027 Without AXI_MEM_SNOOP_EN, W_SNOOP SHALL be unreachable (W_DATA->W_RESP), acvalid/acaddr/acsnoop tied 0, acready ignored.

Structure
REQ-028 Package axi_mem_pkg SHALL hold burst-type and resp constants, read/write state enums, and snoop code SNOOP_MAKE_INVALID=4'hD.
REQ-029 Sub-module axi_burst_addr_gen (addr, size, len, burst -> next addr) SHALL be instantiated once per FSM.

Verification
REQ-030 AR addr 0x100, len 7, size 3, INCR, rready=1 -> 8 beats from 0x100..0x138, first rvalid 2 cycles after handshake, rlast on beat 8.
REQ-031 AR addr 0x130, len 3, size 3, WRAP -> beat addresses 0x130, 0x138, 0x120, 0x128.
REQ-032 AW 0x40 len 0, wdata 0xFFFF_FFFF_FFFF_FFFF, wstrb 0x0F over 0 word -> mem word 0x0000_0000_FFFF_FFFF, bresp 00.
REQ-033 AR addr MEM_WORDS*8, len 1 -> 2 beats rdata 0, rresp 10; rready low 3 cycles -> outputs stable.
REQ-034 With AXI_MEM_SNOOP_EN, AW 0x1048 len 1, acready delayed 4 cycles -> acaddr 0x1040, acsnoop 0xD, bvalid only after AC handshake.
REQ-035 Reset asserted on read beat 3 of 8 -> rvalid 0 next cycle, arready 1 after reset release, previously written data still readable.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared constants and state encodings for the AXI memory responder.
// Contents: burst-type and response codes, the read/write FSM state enums,
//           and the snoop opcode issued on the AC channel.
package axi_mem_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] SNOOP_MAKE_INVALID = 4'hD;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_BURST
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_SNOOP,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// AXI next-beat address calculator (purely combinational, zero latency, no flow control).
// Ports: addr/size/len/burst of the current beat in, next_addr out.
// FIXED keeps the address, WRAP wraps inside a (len+1)<<size window, INCR and
// the reserved encoding step by 1<<size.
module axi_burst_addr_gen #(
   parameter int ADDR_WIDTH = 64
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);
   import axi_mem_pkg::*;

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      step      = ADDR_WIDTH'(1) << size;
      incr_addr = addr + step;
      // Legal wrap lengths make the window a power of two, so the wrap is a
      // masked merge: upper bits from the current address, low bits from the
      // incremented one.
      wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI slave backed by a MEM_WORDS x 64-bit array; concurrent read and write FSMs.
// Ports: clk/reset (sync, active-high); AR/R read channels; AW/W/B write channels;
//        AC snoop channel (active only when AXI_MEM_SNOOP_EN is defined).
// Latency: first R beat READ_LATENCY cycles after the AR handshake; R outputs are
// registered and held while rready is low. Out-of-range beats return SLVERR.
module axi_mem_responder #(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int MEM_WORDS    = 4096,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [63:0]           s_axi_rdata,
   output logic                  s_axi_rlast,
   output logic [1:0]            s_axi_rresp,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [63:0]           s_axi_wdata,
   input  logic [7:0]            s_axi_wstrb,
   input  logic                  s_axi_wlast,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_acvalid,
   input  logic                  s_axi_acready,
   output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
   output logic [3:0]            s_axi_acsnoop
);
   import axi_mem_pkg::*;

   localparam int IDX_W      = $clog2(MEM_WORDS);
   localparam int BEAT_BYTES = DATA_WIDTH / 8;
   localparam logic [7:0] WAIT_LAST = 8'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
   localparam logic [ADDR_WIDTH-4:0] WORD_LIMIT = (ADDR_WIDTH-3)'(MEM_WORDS);

   function automatic logic in_range(input logic [ADDR_WIDTH-4:0] word);
      return word < WORD_LIMIT;
   endfunction

   // Backing store is never reset so contents survive a mid-transaction reset.
   logic [63:0] mem [MEM_WORDS];

   // Read side state
   rd_state_e             r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr;
   logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d, r_wait_q, r_wait_d;
   logic [2:0]            r_size_q, r_size_d;
   logic [1:0]            r_burst_q, r_burst_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [63:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic                  r_fetch, r_fetch_last;
   logic [ADDR_WIDTH-4:0] r_fetch_word;

   // Write side state
   wr_state_e             w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, w_next_addr;
   logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
   logic [2:0]            w_size_q, w_size_d;
   logic [1:0]            w_burst_q, w_burst_d;
   logic                  w_err_q, w_err_d, w_last_beat, w_beat_err;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  mem_we;
`ifdef AXI_MEM_SNOOP_EN
   logic [ADDR_WIDTH-1:0] w_base_q, w_base_d, acaddr_q, acaddr_d;
   logic                  acvalid_q, acvalid_d;
   logic [3:0]            acsnoop_q, acsnoop_d;
`endif

   axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr_gen (
      .addr(r_addr_q), .size(r_size_q), .len(r_len_q), .burst(r_burst_q),
      .next_addr(r_next_addr)
   );

   axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr_gen (
      .addr(w_addr_q), .size(w_size_q), .len(w_len_q), .burst(w_burst_q),
      .next_addr(w_next_addr)
   );

   // Read FSM: the R output registers are loaded ("fetched") only when a new
   // beat is presented, which keeps them stable across rready stalls.
   always_comb begin
      r_state_d    = r_state_q;
      r_addr_d     = r_addr_q;
      r_len_d      = r_len_q;
      r_size_d     = r_size_q;
      r_burst_d    = r_burst_q;
      r_beat_d     = r_beat_q;
      r_wait_d     = r_wait_q;
      rvalid_d     = rvalid_q;
      rdata_d      = rdata_q;
      rlast_d      = rlast_q;
      rresp_d      = rresp_q;
      r_fetch      = 1'b0;
      r_fetch_word = r_addr_q[ADDR_WIDTH-1:3];
      r_fetch_last = (r_len_q == 8'd0);
      case (r_state_q)
         R_IDLE: begin
            if (arready_q && s_axi_arvalid) begin
               r_addr_d  = s_axi_araddr;
               r_len_d   = s_axi_arlen;
               r_size_d  = s_axi_arsize;
               r_burst_d = s_axi_arburst;
               r_beat_d  = 8'd0;
               r_wait_d  = 8'd0;
               if (READ_LATENCY > 1) begin
                  r_state_d = R_WAIT;
               end else begin
                  r_state_d    = R_BURST;
                  r_fetch      = 1'b1;
                  r_fetch_word = s_axi_araddr[ADDR_WIDTH-1:3];
                  r_fetch_last = (s_axi_arlen == 8'd0);
               end
            end
         end
         R_WAIT: begin
            if (r_wait_q == WAIT_LAST) begin
               r_state_d = R_BURST;
               r_fetch   = 1'b1;
            end else begin
               r_wait_d = r_wait_q + 8'd1;
            end
         end
         R_BURST: begin
            if (s_axi_rready) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rvalid_d  = 1'b0;
                  rdata_d   = 64'd0;
                  rlast_d   = 1'b0;
                  rresp_d   = RESP_OKAY;
               end else begin
                  r_addr_d     = r_next_addr;
                  r_beat_d     = r_beat_q + 8'd1;
                  r_fetch      = 1'b1;
                  r_fetch_word = r_next_addr[ADDR_WIDTH-1:3];
                  r_fetch_last = ((r_beat_q + 8'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (r_fetch) begin
         rvalid_d = 1'b1;
         rlast_d  = r_fetch_last;
         if (in_range(r_fetch_word)) begin
            rdata_d = mem[r_fetch_word[IDX_W-1:0]];
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = 64'd0;
            rresp_d = RESP_SLVERR;
         end
      end
      arready_d = (r_state_d == R_IDLE);
   end

   // Write FSM: errors (out-of-range beat, misplaced wlast) accumulate over
   // the burst and are reported once in bresp.
   always_comb begin
      w_state_d   = w_state_q;
      w_addr_d    = w_addr_q;
      w_len_d     = w_len_q;
      w_size_d    = w_size_q;
      w_burst_d   = w_burst_q;
      w_beat_d    = w_beat_q;
      w_err_d     = w_err_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      mem_we      = 1'b0;
      w_last_beat = (w_beat_q == w_len_q);
      w_beat_err  = !in_range(w_addr_q[ADDR_WIDTH-1:3]) || (s_axi_wlast != w_last_beat);
`ifdef AXI_MEM_SNOOP_EN
      w_base_d    = w_base_q;
      acvalid_d   = acvalid_q;
      acaddr_d    = acaddr_q;
      acsnoop_d   = acsnoop_q;
`endif
      case (w_state_q)
         W_IDLE: begin
            if (awready_q && s_axi_awvalid) begin
               w_state_d = W_DATA;
               w_addr_d  = s_axi_awaddr;
               w_len_d   = s_axi_awlen;
               w_size_d  = s_axi_awsize;
               w_burst_d = s_axi_awburst;
               w_beat_d  = 8'd0;
               w_err_d   = 1'b0;
`ifdef AXI_MEM_SNOOP_EN
               w_base_d  = s_axi_awaddr;
`endif
            end
         end
         W_DATA: begin
            if (wready_q && s_axi_wvalid) begin
               mem_we  = in_range(w_addr_q[ADDR_WIDTH-1:3]);
               w_err_d = w_err_q || w_beat_err;
               if (w_last_beat) begin
`ifdef AXI_MEM_SNOOP_EN
                  w_state_d = W_SNOOP;
                  acvalid_d = 1'b1;
                  acaddr_d  = w_base_q & ~(ADDR_WIDTH'(6'h3F));
                  acsnoop_d = SNOOP_MAKE_INVALID;
`else
                  w_state_d = W_RESP;
                  bvalid_d  = 1'b1;
                  bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
`endif
               end else begin
                  w_addr_d = w_next_addr;
                  w_beat_d = w_beat_q + 8'd1;
               end
            end
         end
         W_SNOOP: begin
`ifdef AXI_MEM_SNOOP_EN
            if (s_axi_acready) begin
               w_state_d = W_RESP;
               acvalid_d = 1'b0;
               acaddr_d  = '0;
               acsnoop_d = 4'd0;
               bvalid_d  = 1'b1;
               bresp_d   = w_err_q ? RESP_SLVERR : RESP_OKAY;
            end
`else
            w_state_d = W_IDLE;
`endif
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_len_q   <= 8'd0;
         r_size_q  <= 3'd0;
         r_burst_q <= 2'd0;
         r_beat_q  <= 8'd0;
         r_wait_q  <= 8'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 64'd0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'd0;
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_len_q   <= 8'd0;
         w_size_q  <= 3'd0;
         w_burst_q <= 2'd0;
         w_beat_q  <= 8'd0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'd0;
`ifdef AXI_MEM_SNOOP_EN
         w_base_q  <= '0;
         acvalid_q <= 1'b0;
         acaddr_q  <= '0;
         acsnoop_q <= 4'd0;
`endif
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_beat_q  <= r_beat_d;
         r_wait_q  <= r_wait_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_beat_q  <= w_beat_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
`ifdef AXI_MEM_SNOOP_EN
         w_base_q  <= w_base_d;
         acvalid_q <= acvalid_d;
         acaddr_q  <= acaddr_d;
         acsnoop_q <= acsnoop_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < BEAT_BYTES; b++) begin
            if (s_axi_wstrb[b]) begin
               mem[w_addr_q[IDX_W+2:3]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
         end
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
`ifdef AXI_MEM_SNOOP_EN
   assign s_axi_acvalid = acvalid_q;
   assign s_axi_acaddr  = acaddr_q;
   assign s_axi_acsnoop = acsnoop_q;
`else
   logic unused_acready;
   assign unused_acready = s_axi_acready;
   assign s_axi_acvalid  = 1'b0;
   assign s_axi_acaddr   = '0;
   assign s_axi_acsnoop  = 4'd0;
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder (default parameters).
// Ports: drives every AXI channel of the DUT; samples outputs 1ns after posedge.
// The AC-channel steps follow AXI_MEM_SNOOP_EN the same way the design does.
module tb_axi_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_axi_arvalid, s_axi_arready;
   logic [63:0] s_axi_araddr;
   logic [7:0]  s_axi_arlen;
   logic [2:0]  s_axi_arsize;
   logic [1:0]  s_axi_arburst;
   logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_awvalid, s_axi_awready;
   logic [63:0] s_axi_awaddr;
   logic [7:0]  s_axi_awlen;
   logic [2:0]  s_axi_awsize;
   logic [1:0]  s_axi_awburst;
   logic        s_axi_wvalid, s_axi_wready, s_axi_wlast;
   logic [63:0] s_axi_wdata;
   logic [7:0]  s_axi_wstrb;
   logic        s_axi_bvalid, s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_acvalid, s_axi_acready;
   logic [63:0] s_axi_acaddr;
   logic [3:0]  s_axi_acsnoop;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .clk(clk), .reset(reset),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready),
      .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop)
   );

   int checks   = 0;
   int failures = 0;
   logic [63:0] model [0:4095];
   logic [63:0] exp_addr [0:15];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_rd(input logic [63:0] a);
      if (a[63:3] >= 61'd4096) return 64'd0;
      return model[a[14:3]];
   endfunction

   // Issues one AR and waits (bounded) for the first R beat; lat counts sample
   // points from the handshake edge to rvalid.
   task automatic ar_send(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int lat);
      s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arsize = 3'd3; s_axi_arburst = burst;
      tick;
      s_axi_arvalid = 1'b0;
      lat = 1;
      while (!s_axi_rvalid && lat < 10) begin
         tick;
         lat++;
      end
   endtask

   // Reads a burst with rready held high and checks each beat against exp_addr.
   task automatic read_check(input string tag, input logic [63:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
      int lat;
      s_axi_rready = 1'b1;
      chk({tag, ":arready"}, 64'(s_axi_arready), 64'd1);
      ar_send(addr, len, burst, lat);
      chk({tag, ":latency"}, 64'(lat), 64'd2);
      for (int i = 0; i <= int'(len); i++) begin
         chk($sformatf("%s:rvalid%0d", tag, i), 64'(s_axi_rvalid), 64'd1);
         chk($sformatf("%s:rdata%0d", tag, i), s_axi_rdata, model_rd(exp_addr[i]));
         chk($sformatf("%s:rlast%0d", tag, i), 64'(s_axi_rlast), 64'(i == int'(len)));
         chk($sformatf("%s:rresp%0d", tag, i), 64'(s_axi_rresp),
             (exp_addr[i][63:3] >= 61'd4096) ? 64'd2 : 64'd0);
         tick;
      end
      chk({tag, ":rvalid_end"}, 64'(s_axi_rvalid), 64'd0);
      chk({tag, ":arready_end"}, 64'(s_axi_arready), 64'd1);
   endtask

   // INCR size-3 write burst; beat i carries seed+i. bad_last moves wlast to beat 0.
   task automatic write_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                              input logic [63:0] seed, input logic [7:0] strb,
                              input bit bad_last, input logic [1:0] exp_bresp);
      int n;
      logic [63:0] a;
      chk({tag, ":awready"}, 64'(s_axi_awready), 64'd1);
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
      s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
      tick;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         n = 0;
         while (!s_axi_wready && n < 10) begin
            tick;
            n++;
         end
         chk($sformatf("%s:wready%0d", tag, i), 64'(s_axi_wready), 64'd1);
         a = addr + 64'(8 * i);
         s_axi_wvalid = 1'b1;
         s_axi_wdata  = seed + 64'(i);
         s_axi_wstrb  = strb;
         s_axi_wlast  = bad_last ? (i == 0) : (i == int'(len));
         if (a[63:3] < 61'd4096) begin
            for (int b = 0; b < 8; b++) begin
               if (strb[b]) model[a[14:3]][8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
         end
         tick;
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      n = 0;
      while (!s_axi_bvalid && n < 20) begin
         tick;
         n++;
      end
      chk({tag, ":bvalid"}, 64'(s_axi_bvalid), 64'd1);
      chk({tag, ":bresp"}, 64'(s_axi_bresp), 64'(exp_bresp));
      s_axi_bready = 1'b1;
      tick;
      s_axi_bready = 1'b0;
      chk({tag, ":bvalid_clr"}, 64'(s_axi_bvalid), 64'd0);
   endtask

   initial begin
      int lat;
      for (int i = 0; i < 4096; i++) model[i] = 64'd0;
      reset = 1'b1;
      s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
      s_axi_rready  = 1'b0;
      s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
      s_axi_wvalid  = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_acready = 1'b1;

      // Reset state
      repeat (3) tick;
      chk("rst:arready", 64'(s_axi_arready), 64'd0);
      chk("rst:awready", 64'(s_axi_awready), 64'd0);
      chk("rst:wready",  64'(s_axi_wready),  64'd0);
      chk("rst:rvalid",  64'(s_axi_rvalid),  64'd0);
      chk("rst:bvalid",  64'(s_axi_bvalid),  64'd0);
      chk("rst:acvalid", 64'(s_axi_acvalid), 64'd0);
      chk("rst:rdata",   s_axi_rdata,        64'd0);
      chk("rst:acaddr",  s_axi_acaddr,       64'd0);
      reset = 1'b0;
      tick;
      chk("idle:arready", 64'(s_axi_arready), 64'd1);
      chk("idle:awready", 64'(s_axi_awready), 64'd1);

      // Fill words 0x100..0x178, then the strobe test on word 0x40
      write_burst("wr_blk", 64'h100, 8'd15, 64'hA5A5_0000_0000_0100, 8'hFF, 1'b0, 2'b00);
      write_burst("wr_w40_clr", 64'h40, 8'd0, 64'd0, 8'hFF, 1'b0, 2'b00);
      write_burst("wr_w40_strb", 64'h40, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 2'b00);
      s_axi_rready = 1'b1;
      ar_send(64'h40, 8'd0, 2'b01, lat);
      chk("strb:rdata", s_axi_rdata, 64'h0000_0000_FFFF_FFFF);
      chk("strb:rlast", 64'(s_axi_rlast), 64'd1);
      tick;

      // INCR 8 beats from 0x100
      for (int i = 0; i < 8; i++) exp_addr[i] = 64'h100 + 64'(8 * i);
      read_check("rd_incr", 64'h100, 8'd7, 2'b01);

      // WRAP 4 beats from 0x130
      exp_addr[0] = 64'h130; exp_addr[1] = 64'h138; exp_addr[2] = 64'h120; exp_addr[3] = 64'h128;
      read_check("rd_wrap", 64'h130, 8'd3, 2'b10);

      // FIXED 3 beats at 0x108
      for (int i = 0; i < 3; i++) exp_addr[i] = 64'h108;
      read_check("rd_fixed", 64'h108, 8'd2, 2'b00);

      // Write errors: wlast on the wrong beat, out-of-range address
      write_burst("wr_badlast", 64'h160, 8'd1, 64'h1234_5678_0000_0000, 8'hFF, 1'b1, 2'b10);
      write_burst("wr_oob", 64'h8000, 8'd0, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 2'b10);
      exp_addr[0] = 64'h160; exp_addr[1] = 64'h168;
      read_check("rd_badlast", 64'h160, 8'd1, 2'b01);

      // Out-of-range read with a 3-cycle rready stall on beat 1
      s_axi_rready = 1'b0;
      ar_send(64'h8000, 8'd1, 2'b01, lat);
      chk("oob:latency", 64'(lat), 64'd2);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("oob:stall_rvalid%0d", k), 64'(s_axi_rvalid), 64'd1);
         chk($sformatf("oob:stall_rdata%0d", k),  s_axi_rdata,        64'd0);
         chk($sformatf("oob:stall_rresp%0d", k),  64'(s_axi_rresp),  64'd2);
         chk($sformatf("oob:stall_rlast%0d", k),  64'(s_axi_rlast),  64'd0);
         tick;
      end
      s_axi_rready = 1'b1;
      chk("oob:beat0_rlast", 64'(s_axi_rlast), 64'd0);
      tick;
      chk("oob:beat1_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("oob:beat1_rdata",  s_axi_rdata,        64'd0);
      chk("oob:beat1_rresp",  64'(s_axi_rresp),  64'd2);
      chk("oob:beat1_rlast",  64'(s_axi_rlast),  64'd1);
      tick;
      chk("oob:rvalid_end", 64'(s_axi_rvalid), 64'd0);

`ifdef AXI_MEM_SNOOP_EN
      // Snoop: AC held for 4 cycles with acready low, B only after AC handshake
      s_axi_acready = 1'b0;
      s_axi_awvalid = 1'b1; s_axi_awaddr = 64'h1048; s_axi_awlen = 8'd1;
      s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
      tick;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("snp:wready%0d", i), 64'(s_axi_wready), 64'd1);
         s_axi_wvalid = 1'b1; s_axi_wdata = 64'h5A00 + 64'(i); s_axi_wstrb = 8'hFF;
         s_axi_wlast = (i == 1);
         model[(12'h209 + 12'(i))] = s_axi_wdata;
         tick;
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("snp:acvalid%0d", k), 64'(s_axi_acvalid), 64'd1);
         chk($sformatf("snp:acaddr%0d", k),  s_axi_acaddr,        64'h1040);
         chk($sformatf("snp:acsnoop%0d", k), 64'(s_axi_acsnoop), 64'hD);
         chk($sformatf("snp:bvalid%0d", k),  64'(s_axi_bvalid),  64'd0);
         tick;
      end
      s_axi_acready = 1'b1;
      tick;
      chk("snp:acvalid_clr", 64'(s_axi_acvalid), 64'd0);
      chk("snp:bvalid", 64'(s_axi_bvalid), 64'd1);
      chk("snp:bresp", 64'(s_axi_bresp), 64'd0);
      s_axi_bready = 1'b1;
      tick;
      s_axi_bready = 1'b0;
      chk("snp:bvalid_clr", 64'(s_axi_bvalid), 64'd0);
`else
      // Without snoop support the write completes with acready low and AC idle
      s_axi_acready = 1'b0;
      write_burst("wr_nosnp", 64'h1048, 8'd1, 64'h5A00, 8'hFF, 1'b0, 2'b00);
      chk("nosnp:acvalid", 64'(s_axi_acvalid), 64'd0);
      chk("nosnp:acaddr",  s_axi_acaddr,        64'd0);
      chk("nosnp:acsnoop", 64'(s_axi_acsnoop), 64'd0);
      s_axi_acready = 1'b1;
`endif
      exp_addr[0] = 64'h1048; exp_addr[1] = 64'h1050;
      read_check("rd_1048", 64'h1048, 8'd1, 2'b01);

      // Reset on beat 3 of 8
      s_axi_rready = 1'b1;
      ar_send(64'h100, 8'd7, 2'b01, lat);
      tick;
      tick;
      chk("rstmid:beat3_rdata", s_axi_rdata, model_rd(64'h110));
      reset = 1'b1;
      tick;
      chk("rstmid:rvalid", 64'(s_axi_rvalid), 64'd0);
      tick;
      reset = 1'b0;
      tick;
      chk("rstmid:arready", 64'(s_axi_arready), 64'd1);
      chk("rstmid:rvalid_after", 64'(s_axi_rvalid), 64'd0);
      chk("rstmid:bvalid_after", 64'(s_axi_bvalid), 64'd0);
      for (int i = 0; i < 4; i++) exp_addr[i] = 64'h100 + 64'(8 * i);
      read_check("rd_after_rst", 64'h100, 8'd3, 2'b01);
      chk("rstmid:const_word0", s_axi_rdata, 64'd0);
      exp_addr[0] = 64'h40;
      read_check("rd_w40_after_rst", 64'h40, 8'd0, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
